// File: rtl/rf_wb_sched.sv
// rtl/rf_wb_sched.sv - register-file write-back scheduler with B-destination scoreboard
//
// Purpose:
//   Shares the single register-file write port between a single-cycle ALU
//   producer (A) and a long-latency producer (B). A normally has priority.
//   B is forced to win after MAX_WAIT consecutive denied cycles. The chosen
//   write is registered onto the write port one cycle after the grant.
//   A pending-write scoreboard tracks issued B destinations. It gates new
//   B issues (WAW) and stalls decode on read hazards.
//
// Optional feature macro: WB_BYPASS_EN
//   Adds o_byp1_sel / o_byp2_sel / o_byp_data, which forward the in-flight
//   write to decode. When enabled, only the pending bits raise o_stall.
//
// Ports:
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_a_valid/o_a_ready/i_a_rd/i_a_data   producer A result handshake
//   i_b_valid/o_b_ready/i_b_rd/i_b_data   producer B result handshake
//   i_iss_valid/i_iss_rd/o_iss_ready      decode issue of a B-type op
//   i_rs1, i_rs2, o_stall                 decode source hazard check
//   o_rf_we, o_rf_waddr, o_rf_wdata       register-file write port
//   o_sb_err                              sticky: B wrote a non-pending reg
//   o_byp1_sel, o_byp2_sel, o_byp_data    (WB_BYPASS_EN only) forwarding

module rf_wb_sched #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_valid,
  output logic        o_a_ready,
  input  logic [4:0]  i_a_rd,
  input  logic [31:0] i_a_data,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [4:0]  i_b_rd,
  input  logic [31:0] i_b_data,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_rd,
  output logic        o_iss_ready,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic        o_stall,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_sb_err
`ifdef WB_BYPASS_EN
  ,
  output logic        o_byp1_sel,
  output logic        o_byp2_sel,
  output logic [31:0] o_byp_data
`endif
);

  localparam logic [0:0] PRIO_A = 1'b0;
  localparam logic [0:0] PRIO_B = 1'b1;

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [31:0]      r_pending;
  logic             r_rf_we;
  logic [4:0]       r_rf_waddr;
  logic [31:0]      r_rf_wdata;
  logic             r_sb_err;

  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_iss_ready;
  logic             w_iss_fire;
  logic [31:0]      w_pending_nxt;
  logic             w_fwd1;
  logic             w_fwd2;
  logic             w_haz1;
  logic             w_haz2;

  assign w_cnt_inc = r_wait_cnt + 1'b1;

  // Arbitration and starvation tracking
  always_comb begin
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_wait_cnt;
    case (r_state)
      PRIO_A: begin
        w_grant_a = i_a_valid;
        w_grant_b = !i_a_valid && i_b_valid;
        if (!i_b_valid || w_grant_b) begin
          w_cnt_nxt = '0;
        end else if (w_cnt_inc == MAX_WAIT_C) begin
          // B has now been denied MAX_WAIT times in a row: it wins next cycle.
          w_cnt_nxt   = '0;
          w_state_nxt = PRIO_B;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      PRIO_B: begin
        w_grant_b = i_b_valid;
        w_grant_a = !i_b_valid && i_a_valid;
        w_cnt_nxt = '0;
        // Every PRIO_B cycle either grants B or sees b_valid low.
        if (w_grant_b || !i_b_valid) begin
          w_state_nxt = PRIO_A;
        end
      end
      default: begin
        w_state_nxt = PRIO_A;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_a_ready = w_grant_a;
  assign o_b_ready = w_grant_b;

  // Scoreboard: issue acceptance uses only the registered pending vector.
  assign w_iss_ready = !r_pending[i_iss_rd] || (i_iss_rd == 5'd0);
  assign w_iss_fire  = i_iss_valid && w_iss_ready && (i_iss_rd != 5'd0);
  assign o_iss_ready = w_iss_ready;

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_grant_b) begin
      w_pending_nxt[i_b_rd] = 1'b0;
    end
    // Applied after the clear so a same-index set wins.
    if (w_iss_fire) begin
      w_pending_nxt[i_iss_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= PRIO_A;
      r_wait_cnt <= '0;
      r_pending  <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
      r_sb_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
      if (w_grant_a) begin
        r_rf_we    <= (i_a_rd != 5'd0);
        r_rf_waddr <= i_a_rd;
        r_rf_wdata <= i_a_data;
      end else if (w_grant_b) begin
        r_rf_we    <= (i_b_rd != 5'd0);
        r_rf_waddr <= i_b_rd;
        r_rf_wdata <= i_b_data;
      end else begin
        r_rf_we <= 1'b0;
      end
      if (w_grant_b && (i_b_rd != 5'd0) && !r_pending[i_b_rd]) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;
  assign o_sb_err   = r_sb_err;

  // A write landing this cycle is not yet visible to the asynchronous read.
  assign w_fwd1 = r_rf_we && (r_rf_waddr == i_rs1) && (i_rs1 != 5'd0);
  assign w_fwd2 = r_rf_we && (r_rf_waddr == i_rs2) && (i_rs2 != 5'd0);

`ifdef WB_BYPASS_EN
  assign w_haz1     = (i_rs1 != 5'd0) && r_pending[i_rs1];
  assign w_haz2     = (i_rs2 != 5'd0) && r_pending[i_rs2];
  assign o_byp1_sel = w_fwd1;
  assign o_byp2_sel = w_fwd2;
  assign o_byp_data = r_rf_wdata;
`else
  assign w_haz1 = ((i_rs1 != 5'd0) && r_pending[i_rs1]) || w_fwd1;
  assign w_haz2 = ((i_rs2 != 5'd0) && r_pending[i_rs2]) || w_fwd2;
`endif

  assign o_stall = w_haz1 || w_haz2;

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb/tb_rf_wb_sched.sv - directed self-checking bench for rf_wb_sched
module tb_rf_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_err;

  int checks;
  int failures;

  rf_wb_sched #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a_valid   (a_valid),
    .o_a_ready   (a_ready),
    .i_a_rd      (a_rd),
    .i_a_data    (a_data),
    .i_b_valid   (b_valid),
    .o_b_ready   (b_ready),
    .i_b_rd      (b_rd),
    .i_b_data    (b_data),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .o_stall     (stall),
    .o_rf_we     (rf_we),
    .o_rf_waddr  (rf_waddr),
    .o_rf_wdata  (rf_wdata),
    .o_sb_err    (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_a [6];
    exp_a = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    a_rd      = 5'd0;
    a_data    = 32'd0;
    b_valid   = 1'b0;
    b_rd      = 5'd0;
    b_data    = 32'd0;
    iss_valid = 1'b0;
    iss_rd    = 5'd7;
    rs1       = 5'd0;
    rs2       = 5'd0;

    // Reset state
    #12;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_sb_err", 32'(sb_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    #5 rst_n = 1'b1;
    cyc();

    // Single A write, one-cycle latency
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
    #1;
    chk("a_ready", 32'(a_ready), 32'd1);
    chk("a_only_b_ready", 32'(b_ready), 32'd0);
    cyc();
    a_valid = 1'b0;
    chk("a_wr_we", 32'(rf_we), 32'd1);
    chk("a_wr_waddr", 32'(rf_waddr), 32'd5);
    chk("a_wr_wdata", rf_wdata, 32'h1234);
    cyc();
    chk("a_wr_we_idle", 32'(rf_we), 32'd0);

    // Starvation: A four times, then B, then A again
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA0;
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("starve_a_ready_%0d", i), 32'(a_ready), 32'(exp_a[i]));
      chk($sformatf("starve_b_ready_%0d", i), 32'(b_ready), 32'(!exp_a[i]));
      cyc();
      chk($sformatf("starve_we_%0d", i), 32'(rf_we), 32'(exp_a[i]));
    end
    a_valid = 1'b0; b_valid = 1'b0;
    cyc();

    // Scoreboard: issue r7, hazard, B write-back clears it
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    chk("iss7_ready", 32'(iss_ready), 32'd1);
    cyc();
    iss_valid = 1'b0; rs1 = 5'd7;
    #1;
    chk("iss7_waw_block", 32'(iss_ready), 32'd0);
    chk("rs1_7_stall", 32'(stall), 32'd1);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hBEEF;
    #1;
    chk("b7_ready", 32'(b_ready), 32'd1);
    cyc();
    b_valid = 1'b0;
    #1;
    chk("b7_we", 32'(rf_we), 32'd1);
    chk("b7_waddr", 32'(rf_waddr), 32'd7);
    chk("b7_wdata", rf_wdata, 32'hBEEF);
    chk("b7_inflight_stall", 32'(stall), 32'd1);
    chk("b7_iss_ready", 32'(iss_ready), 32'd1);
    chk("b7_no_sb_err", 32'(sb_err), 32'd0);
    cyc();
    chk("b7_stall_clear", 32'(stall), 32'd0);
    rs1 = 5'd0;

    // x0 destination: handshake completes but no write
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
    #1;
    chk("x0_a_ready", 32'(a_ready), 32'd1);
    cyc();
    a_valid = 1'b0;
    #1;
    chk("x0_no_we", 32'(rf_we), 32'd0);

    // B write to a non-pending register sets sticky sb_err
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9;
    #1;
    chk("b9_ready", 32'(b_ready), 32'd1);
    cyc();
    b_valid = 1'b0;
    chk("sb_err_set", 32'(sb_err), 32'd1);
    cyc();
    cyc();
    chk("sb_err_sticky", 32'(sb_err), 32'd1);

    // Same-cycle set and clear on r3: the set wins
    iss_valid = 1'b1; iss_rd = 5'd3;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h33;
    #1;
    chk("sw_iss_ready", 32'(iss_ready), 32'd1);
    chk("sw_b_ready", 32'(b_ready), 32'd1);
    cyc();
    iss_valid = 1'b0; b_valid = 1'b0; rs1 = 5'd3;
    #1;
    chk("sw_we", 32'(rf_we), 32'd1);
    chk("sw_stall", 32'(stall), 32'd1);
    chk("sw_pending_kept", 32'(iss_ready), 32'd0);
    cyc();
    chk("sw_we_idle", 32'(rf_we), 32'd0);
    chk("sw_stall_pending", 32'(stall), 32'd1);

    // Fill every pending bit, then x0 sources never stall
    iss_valid = 1'b1;
    for (int r = 1; r < 32; r++) begin
      iss_rd = 5'(r);
      cyc();
    end
    iss_valid = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    chk("rs_zero_no_stall", 32'(stall), 32'd0);
    rs2 = 5'd31;
    #1;
    chk("rs2_31_stall", 32'(stall), 32'd1);
    rs2 = 5'd0; rs1 = 5'd3;

    // Reset mid-stream clears everything asynchronously
    a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h44;
    cyc();
    a_valid = 1'b0;
    chk("pre_rst_we", 32'(rf_we), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    chk("mid_rst_wdata", rf_wdata, 32'd0);
    chk("mid_rst_sb_err", 32'(sb_err), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    iss_rd = 5'd3;
    #1;
    chk("mid_rst_iss_ready", 32'(iss_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
